// File: rtl/dual_rail_func_pipe_pkg.sv
// Shared types and helpers for the dual-rail truth-table function pipeline.
package dual_rail_func_pipe_pkg;

    localparam logic [15:0] TT_INIT_DEFAULT = 16'hFC51;

    typedef struct packed {
        logic s0_free;
        logic s1_free;
    } pipe_ctrl_t;

    function automatic int unsigned tt_width(input int unsigned n_in, input int unsigned channels);
        return channels * (32'd1 << n_in);
    endfunction

endpackage

// File: rtl/dual_rail_func_pipe_tg_mux2.sv
// Transmission-gate 2:1 mux: one pmos/nmos pair per leg, driven by complementary selects.
module dual_rail_func_pipe_tg_mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    input  logic sel_n,
    output wire  y
);

    nmos (y, b, sel);
    pmos (y, b, sel_n);
    nmos (y, a, sel_n);
    pmos (y, a, sel);

endmodule

// File: rtl/dual_rail_func_pipe.sv
// Two-stage valid/ready pipeline evaluating CHANNELS truth-table functions of an N_IN-bit vector
// through dual-rail transmission-gate mux trees.
module dual_rail_func_pipe
    import dual_rail_func_pipe_pkg::*;
#(
    parameter int unsigned                         N_IN     = 4,
    parameter int unsigned                         CHANNELS = 1,
    parameter logic [tt_width(N_IN, CHANNELS)-1:0] TT_INIT  = TT_INIT_DEFAULT,
    parameter bit                                  RUNTIME  = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_IN-1:0]                      in_data,
    input  logic                                 tt_load,
    input  logic [tt_width(N_IN, CHANNELS)-1:0]  tt_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CHANNELS-1:0]                  out_data
);

    localparam int unsigned LEAVES = 32'd1 << N_IN;
    localparam int unsigned TT_W   = tt_width(N_IN, CHANNELS);

    logic             s0_valid_q;
    logic [N_IN-1:0]  s0_data_q;
    logic [TT_W-1:0]  tt_q;
    pipe_ctrl_t       ctrl;

    wire [N_IN-1:0]     rail_t;
    wire [N_IN-1:0]     rail_f;
    wire [CHANNELS-1:0] eval;

    supply1 vdd;
    supply0 gnd;

    always_comb begin
        ctrl.s1_free = ~out_valid | out_ready;
        ctrl.s0_free = ~s0_valid_q | ctrl.s1_free;
    end

    assign in_ready = ctrl.s0_free;
    assign rail_t   = s0_data_q;

    // Complementary rail from a static CMOS inverter per input bit.
    for (genvar i = 0; i < N_IN; i++) begin : g_rail
        pmos (rail_f[i], vdd, rail_t[i]);
        nmos (rail_f[i], gnd, rail_t[i]);
    end

    // Per channel: level 0 muxes leaf pairs on rail 0, each later level halves the node count.
    // Level l outputs occupy node[LEAVES - 2**(N_IN-l) +: 2**(N_IN-1-l)]; the root is node[LEAVES-2].
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        wire [LEAVES-1:0] leaf = tt_q[k*LEAVES +: LEAVES];
        wire [LEAVES-2:0] node;

        for (genvar l = 0; l < N_IN; l++) begin : g_lvl
            localparam int unsigned OFF = LEAVES - (32'd1 << (N_IN - l));
            localparam int unsigned CNT = 32'd1 << (N_IN - 1 - l);
            for (genvar j = 0; j < CNT; j++) begin : g_mux
                if (l == 0) begin : g_leaf
                    dual_rail_func_pipe_tg_mux2 u_mux (
                        .a     (leaf[2*j]),
                        .b     (leaf[2*j+1]),
                        .sel   (rail_t[l]),
                        .sel_n (rail_f[l]),
                        .y     (node[OFF+j])
                    );
                end else begin : g_inner
                    localparam int unsigned PREV = LEAVES - (32'd1 << (N_IN - l + 1));
                    dual_rail_func_pipe_tg_mux2 u_mux (
                        .a     (node[PREV+2*j]),
                        .b     (node[PREV+2*j+1]),
                        .sel   (rail_t[l]),
                        .sel_n (rail_f[l]),
                        .y     (node[OFF+j])
                    );
                end
            end
        end

        assign eval[k] = node[LEAVES-2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            tt_q       <= TT_INIT;
        end else begin
            if (ctrl.s1_free) begin
                out_valid <= s0_valid_q;
                if (s0_valid_q) begin
                    out_data <= eval;
                end
            end
            if (ctrl.s0_free) begin
                s0_valid_q <= in_valid;
                if (in_valid) begin
                    s0_data_q <= in_data;
                end
            end
            // A same-edge transfer above samples eval from the old table.
            if (RUNTIME && tt_load) begin
                tt_q <= tt_data;
            end
        end
    end

endmodule
